// File: rtl/mat_stream_tx.sv
// mat_stream_tx: ROWS x COLS register matrix streamed out LSB-byte-first over a valid/ready byte handshake.
// Ports: clk, rst (sync, active-high); wr_en/wr_addr/wr_data write port (idle only, wr_err on drop);
// start/transpose launch a row- or column-major transfer; tx_valid/tx_data/tx_ready byte stream;
// busy while not idle, done pulses in the final cycle. Define MAT_STREAM_TX_CHECKSUM_EN to append an XOR checksum byte.
module mat_stream_tx #(
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              transpose,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);
  localparam int N  = ROWS * COLS;
  localparam int AW = N > 1 ? $clog2(N) : 1;
  localparam int NB = DATA_W / 8;
  typedef enum logic [2:0] {
    IDLE, RD, LOAD, SEND,
`ifdef MAT_STREAM_TX_CHECKSUM_EN
    CHK,
`endif
    FIN
  } state_t;
  state_t state, nxt, tail;
  logic [DATA_W-1:0] mem [N];
  logic [DATA_W-1:0] rd_q, sh;
  logic [3:0] r, c;
  logic [1:0] bc;
  logic tr, wr_ok, last_byte, last_elem, take;
  logic [AW-1:0] rd_addr;
  logic [7:0] acc;
  assign wr_ok = wr_en && state == IDLE && 32'(wr_addr) < N;
  assign rd_addr = AW'(32'(r) * COLS + 32'(c));
  assign last_byte = bc == 2'(NB - 1);
  assign last_elem = r == 4'(ROWS - 1) && c == 4'(COLS - 1);
  assign take = state == SEND && tx_ready;
`ifdef MAT_STREAM_TX_CHECKSUM_EN
  assign tail = CHK;
`else
  assign tail = FIN;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? RD : IDLE;
      RD:      nxt = LOAD;
      LOAD:    nxt = SEND;
      SEND:    nxt = tx_ready && last_byte ? (last_elem ? tail : RD) : SEND;
`ifdef MAT_STREAM_TX_CHECKSUM_EN
      CHK:     nxt = tx_ready ? FIN : CHK;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == FIN;
`ifdef MAT_STREAM_TX_CHECKSUM_EN
    tx_valid = state == SEND || state == CHK;
    tx_data  = state == SEND ? sh[7:0] : state == CHK ? acc : 8'h00;
`else
    tx_valid = state == SEND;
    tx_data  = state == SEND ? sh[7:0] : 8'h00;
`endif
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr[AW-1:0]] <= wr_data;
    rd_q <= mem[rd_addr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      r      <= '0;
      c      <= '0;
      bc     <= '0;
      tr     <= 1'b0;
      acc    <= '0;
      wr_err <= 1'b0;
      sh     <= '0;
    end else begin
      state  <= nxt;
      wr_err <= wr_en && !wr_ok;
      if (state == IDLE && start) begin
        tr  <= transpose;
        r   <= '0;
        c   <= '0;
        bc  <= '0;
        acc <= '0;
      end
      if (state == LOAD) begin
        sh <= rd_q;
        bc <= '0;
      end
      if (take) begin
        sh  <= sh >> 8;
        bc  <= bc + 2'd1;
        acc <= acc ^ sh[7:0];
        if (last_byte && tr) begin
          r <= r == 4'(ROWS - 1) ? 4'd0 : r + 4'd1;
          c <= r == 4'(ROWS - 1) ? c + 4'd1 : c;
        end else if (last_byte) begin
          c <= c == 4'(COLS - 1) ? 4'd0 : c + 4'd1;
          r <= c == 4'(COLS - 1) ? r + 4'd1 : r;
        end
      end
    end
  end
endmodule

// File: tb/tb_mat_stream_tx.sv
// tb_mat_stream_tx: directed self-checking bench for mat_stream_tx (2x2 x 8-bit and 1x2 x 16-bit instances).
module tb_mat_stream_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic wr_en = 1'b0, start = 1'b0, transpose = 1'b0, tx_ready = 1'b1;
  logic [7:0] wr_addr = '0, wr_data = '0;
  logic tx_valid, busy, done, wr_err;
  logic [7:0] tx_data;
  logic w_wr_en = 1'b0, w_start = 1'b0, w_tx_ready = 1'b1;
  logic [7:0] w_wr_addr = '0;
  logic [15:0] w_wr_data = '0;
  logic w_tx_valid, w_busy, w_done, w_wr_err;
  logic [7:0] w_tx_data;
  int n_checks = 0, n_fail = 0;
  logic [7:0] got [16];
`ifdef MAT_STREAM_TX_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  logic [7:0] exp_row [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
  logic [7:0] exp_col [5] = '{8'h11, 8'h33, 8'h22, 8'h44, 8'h44};
  logic [7:0] exp_w   [5] = '{8'hB2, 8'hA1, 8'hD4, 8'hC3, 8'h04};

  mat_stream_tx dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .transpose(transpose), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .done(done), .wr_err(wr_err)
  );
  mat_stream_tx #(.ROWS(1), .COLS(2), .DATA_W(16), .ADDR_W(8)) dut16 (
    .clk(clk), .rst(rst), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .start(w_start), .transpose(1'b0), .tx_valid(w_tx_valid), .tx_data(w_tx_data),
    .tx_ready(w_tx_ready), .busy(w_busy), .done(w_done), .wr_err(w_wr_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Runs one transfer for 40 cycles; pulse_at >= 0 pulses start at that cycle, -2 pulses start during FIN.
  task automatic collect(input logic tr, input int stall, input int pulse_at,
                         output int nb, output int ndone, output int first_valid,
                         output int busy_gap, output int stall_bad, output logic busy_after_fin);
    int fin_seen = 0;
    int stall_left = stall;
    start = 1'b1; transpose = tr;
    tick();
    start = 1'b0;
    nb = 0; ndone = 0; first_valid = -1; busy_gap = 0; stall_bad = 0; busy_after_fin = 1'bx;
    for (int i = 0; i < 40; i++) begin
      if (fin_seen == 1) begin busy_after_fin = busy; fin_seen = 2; end
      if (tx_valid && first_valid < 0) first_valid = i;
      if (ndone == 0 && !busy) busy_gap++;
      start = (i == pulse_at) || (pulse_at == -2 && done);
      transpose = ~tr;
      if (done) begin ndone++; if (fin_seen == 0) fin_seen = 1; end
      if (tx_valid && stall_left > 0) begin
        tx_ready = 1'b0;
        if (tx_data !== 8'h11) stall_bad++;
        stall_left--;
      end else tx_ready = 1'b1;
      if (tx_valid && tx_ready && nb < 16) begin got[nb] = tx_data; nb++; end
      tick();
    end
    start = 1'b0; transpose = 1'b0; tx_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    n_checks += 5;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    if (wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err got %b want 0", wr_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_row_major;
    int nb, nd, fv, bg, sb;
    logic baf;
    wr(8'd0, 8'h11); wr(8'd1, 8'h22); wr(8'd2, 8'h33); wr(8'd3, 8'h44);
    collect(1'b0, 0, -1, nb, nd, fv, bg, sb, baf);
    n_checks += 4;
    if (nb !== 4 + EXTRA) begin n_fail++; $display("FAIL row_count got %0d want %0d", nb, 4 + EXTRA); end
    if (nd !== 1) begin n_fail++; $display("FAIL row_done_pulses got %0d want 1", nd); end
    if (fv !== 2) begin n_fail++; $display("FAIL row_first_valid_cycle got %0d want 2", fv); end
    if (bg !== 0) begin n_fail++; $display("FAIL row_busy_gap got %0d want 0", bg); end
    for (int k = 0; k < 4 + EXTRA && k < nb; k++) begin
      n_checks++;
      if (got[k] !== exp_row[k]) begin n_fail++; $display("FAIL row_byte%0d got %h want %h", k, got[k], exp_row[k]); end
    end
  endtask

  task automatic test_col_major;
    int nb, nd, fv, bg, sb;
    logic baf;
    collect(1'b1, 0, -1, nb, nd, fv, bg, sb, baf);
    n_checks += 2;
    if (nb !== 4 + EXTRA) begin n_fail++; $display("FAIL col_count got %0d want %0d", nb, 4 + EXTRA); end
    if (nd !== 1) begin n_fail++; $display("FAIL col_done_pulses got %0d want 1", nd); end
    for (int k = 0; k < 4 + EXTRA && k < nb; k++) begin
      n_checks++;
      if (got[k] !== exp_col[k]) begin n_fail++; $display("FAIL col_byte%0d got %h want %h", k, got[k], exp_col[k]); end
    end
  endtask

  task automatic test_start_while_busy;
    int nb, nd, fv, bg, sb;
    logic baf;
    collect(1'b0, 0, 4, nb, nd, fv, bg, sb, baf);
    n_checks += 2;
    if (nb !== 4 + EXTRA) begin n_fail++; $display("FAIL busy_start_count got %0d want %0d", nb, 4 + EXTRA); end
    if (nd !== 1) begin n_fail++; $display("FAIL busy_start_done got %0d want 1", nd); end
    for (int k = 0; k < 4 + EXTRA && k < nb; k++) begin
      n_checks++;
      if (got[k] !== exp_row[k]) begin n_fail++; $display("FAIL busy_start_byte%0d got %h want %h", k, got[k], exp_row[k]); end
    end
  endtask

  task automatic test_done_start;
    int nb, nd, fv, bg, sb;
    logic baf;
    collect(1'b0, 0, -2, nb, nd, fv, bg, sb, baf);
    n_checks += 2;
    if (nd !== 1) begin n_fail++; $display("FAIL fin_start_done got %0d want 1", nd); end
    if (baf !== 1'b0) begin n_fail++; $display("FAIL fin_start_busy got %b want 0", baf); end
  endtask

  task automatic test_backpressure;
    int nb, nd, fv, bg, sb;
    logic baf;
    collect(1'b0, 5, -1, nb, nd, fv, bg, sb, baf);
    n_checks += 3;
    if (sb !== 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", sb); end
    if (nb !== 4 + EXTRA) begin n_fail++; $display("FAIL bp_count got %0d want %0d", nb, 4 + EXTRA); end
    if (nd !== 1) begin n_fail++; $display("FAIL bp_done got %0d want 1", nd); end
    for (int k = 0; k < 4 + EXTRA && k < nb; k++) begin
      n_checks++;
      if (got[k] !== exp_row[k]) begin n_fail++; $display("FAIL bp_byte%0d got %h want %h", k, got[k], exp_row[k]); end
    end
  endtask

  task automatic test_wr_err;
    int nb, nd, fv, bg, sb;
    logic baf;
    wr(8'd4, 8'hFF);
    n_checks++;
    if (wr_err !== 1'b1) begin n_fail++; $display("FAIL wr_err_range got %b want 1", wr_err); end
    tick();
    n_checks++;
    if (wr_err !== 1'b0) begin n_fail++; $display("FAIL wr_err_clear got %b want 0", wr_err); end
    start = 1'b1; transpose = 1'b0;
    tick();
    start = 1'b0;
    wr(8'd0, 8'hEE);
    n_checks += 2;
    if (wr_err !== 1'b1) begin n_fail++; $display("FAIL wr_err_busy got %b want 1", wr_err); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_err_busy_state got %b want 1", busy); end
    for (int i = 0; i < 40 && done !== 1'b1; i++) tick();
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL wr_err_drain_timeout got %b want 1", done); end
    tick();
    collect(1'b0, 0, -1, nb, nd, fv, bg, sb, baf);
    n_checks++;
    if (nb !== 4 + EXTRA) begin n_fail++; $display("FAIL wr_err_restream_count got %0d want %0d", nb, 4 + EXTRA); end
    for (int k = 0; k < 4 + EXTRA && k < nb; k++) begin
      n_checks++;
      if (got[k] !== exp_row[k]) begin n_fail++; $display("FAIL wr_err_byte%0d got %h want %h", k, got[k], exp_row[k]); end
    end
  endtask

  task automatic test_reset_mid;
    int nb, nd, fv, bg, sb;
    int k = 0;
    logic baf;
    start = 1'b1; transpose = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && k < 2; i++) begin
      if (tx_valid) k++;
      tick();
    end
    tick(); tick();
    n_checks += 2;
    if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b want 1", tx_valid); end
    if (tx_data !== 8'h33) begin n_fail++; $display("FAIL mid_pre_data got %h want 33", tx_data); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks += 2;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", tx_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    collect(1'b0, 0, -1, nb, nd, fv, bg, sb, baf);
    n_checks++;
    if (nb !== 4 + EXTRA) begin n_fail++; $display("FAIL mid_restream_count got %0d want %0d", nb, 4 + EXTRA); end
    for (int j = 0; j < 4 + EXTRA && j < nb; j++) begin
      n_checks++;
      if (got[j] !== exp_row[j]) begin n_fail++; $display("FAIL mid_byte%0d got %h want %h", j, got[j], exp_row[j]); end
    end
  endtask

  task automatic test_wide;
    logic [7:0] wg [8];
    int nb = 0, nd = 0;
    w_wr_en = 1'b1; w_wr_addr = 8'd0; w_wr_data = 16'hA1B2;
    tick();
    w_wr_addr = 8'd1; w_wr_data = 16'hC3D4;
    tick();
    w_wr_en = 1'b0; w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (w_tx_valid && nb < 8) begin wg[nb] = w_tx_data; nb++; end
      if (w_done) nd++;
      tick();
    end
    n_checks += 2;
    if (nb !== 4 + EXTRA) begin n_fail++; $display("FAIL wide_count got %0d want %0d", nb, 4 + EXTRA); end
    if (nd !== 1) begin n_fail++; $display("FAIL wide_done got %0d want 1", nd); end
    for (int k = 0; k < 4 + EXTRA && k < nb; k++) begin
      n_checks++;
      if (wg[k] !== exp_w[k]) begin n_fail++; $display("FAIL wide_byte%0d got %h want %h", k, wg[k], exp_w[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_row_major();
    test_col_major();
    test_start_while_busy();
    test_done_start();
    test_backpressure();
    test_wr_err();
    test_reset_mid();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
